universal_shift_reg: RTL and testbench
======================================

# universal_shift_reg

Parametrised universal shift register. The successor to the single-bit clearable flip-flop: a WIDTH-bit register with a synchronous active-high clear, a clock enable, and a mode select covering hold, parallel load, shift and rotate in both directions. It also counts shifts since the last load and flags when a loaded word has been fully shifted out. Used as the serialiser/deserialiser and general-purpose data register in the datapath.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH ≥ 2
- RESET_VALUE, 0, value loaded into q by clear; WIDTH bits

Ports:
- clock  in  1  single clock; all state changes on its rising edge
- clear  in  1  reset: synchronous, active-high; sampled on the rising edge of clock
- enable  in  1  clock enable; when 0 all state holds
- mode  in  3  operation select, see Operation
- d  in  WIDTH  parallel load data
- sin_l  in  1  serial input entering at the MSB (shift right)
- sin_r  in  1  serial input entering at the LSB (shift left)
- q  out  WIDTH  register contents
- sout_l  out  1  equal to q[WIDTH-1]
- sout_r  out  1  equal to q[0]
- shift_count  out  CW = $clog2(WIDTH+1)  shifts/rotates since last load or clear; saturates at WIDTH
- drained  out  1  high when shift_count == WIDTH

## Operation
- Priority at each rising edge: clear > enable == 0 > mode.
- clear = 1: q ← RESET_VALUE, shift_count ← 0. enable and mode are ignored.
- enable = 0: q and shift_count hold.
- Modes with enable = 1:
  - 000 hold: no change to q or count.
  - 001 shift left: q ← {q[WIDTH-2:0], sin_r}; count +1.
  - 010 shift right: q ← {sin_l, q[WIDTH-1:1]}; count +1.
  - 011 load: q ← d; count ← 0.
  - 100 rotate left: q ← {q[WIDTH-2:0], q[WIDTH-1]}; count +1.
  - 101 rotate right: q ← {q[0], q[WIDTH-1:1]}; count +1.
  - 110 soft clear: q ← 0 (not RESET_VALUE); count ← 0.
  - 111 reserved: behaves as hold.
- Count increments saturate at WIDTH. Shifts still occur after saturation; only the count stops.
- drained is decoded combinationally from the shift_count register, so it is glitch-free relative to clock.
- sout_l and sout_r are taken directly from the q register, not from the next-state logic.

## Timing
- Reset values after a clear edge: q = RESET_VALUE, sout_l = RESET_VALUE[WIDTH-1], sout_r = RESET_VALUE[0], shift_count = 0, drained = 0.
- Latency: one cycle. Inputs sampled at edge n appear on q, shift_count and drained after edge n.
- No state until the first clear: q and count are X. The bench must assert clear for at least one edge first.
- clear mid-operation (e.g. partway through a shift-out sequence) overrides on the same edge. There is no partial shift, and count returns to 0.
- Load on the edge after saturation: count returns to 0 and drained falls on that edge.
- clear and enable are both synchronous. Asserting clear while enable = 0 still clears.
- Serial chaining: sout_r of one instance may feed sin_l of another. The bit moves one position per enabled edge, with no combinational path from sin_* to sout_*.

## Test plan
- Reset: WIDTH=8, RESET_VALUE=8'hA5; clear=1 for one edge with enable=0 and mode=011, d=8'hFF -> q=8'hA5, shift_count=0, drained=0, sout_l=1, sout_r=1.
- Load then shift right out: load 8'b1011_0010, then 8 edges of mode 010 with sin_l=0 -> sout_r sequence before each edge is 0,1,0,0,1,1,0,1; final q=8'h00; shift_count=8 and drained=1 after the 8th edge.
- Saturation and rotate: load 8'h81, then 10 edges of mode 100 -> q=8'h06 after edge 10 (rotate by 10 mod 8 = 2); shift_count holds at 8; drained stays 1 from edge 8.
- Enable gating: load 8'h3C, then enable=0 with mode=001 for 5 edges -> q=8'h3C, shift_count=0 throughout. Then enable=1 for one edge of shift left with sin_r=1 -> q=8'h79, count=1.
- Priority and soft clear: load 8'hFF, shift 3 edges (count=3). Then clear=1 together with mode=011 and d=8'h12 -> q=RESET_VALUE, count=0. Then mode 110 -> q=8'h00, count=0. Then mode 111 for 2 edges -> no change.
- Parametric: repeat the load/shift-out test at WIDTH=2 (CW=2) and WIDTH=16 (CW=5) -> drained asserts after exactly WIDTH shifts, and shift_count never exceeds WIDTH.

Source files
------------

// File: rtl/universal_shift_reg_if.sv
// Data/control bundle for universal_shift_reg: mode/enable/serial inputs in,
// register contents and status out. clock and clear stay as plain ports.
interface universal_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             enable;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic [CW-1:0]    shift_count;
  logic             drained;

  modport master (
    output enable, mode, d, sin_l, sin_r,
    input  q, sout_l, sout_r, shift_count, drained
  );

  modport slave (
    input  enable, mode, d, sin_l, sin_r,
    output q, sout_l, sout_r, shift_count, drained
  );
endinterface

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold, load, shift and rotate both ways,
// with a saturating shift counter that flags when a loaded word is drained.
module universal_shift_reg #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                 clock,
  input logic                 clear,
  universal_shift_reg_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_SCLR  = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_r, q_next;
  logic [CW-1:0]    count_r, count_next;
  logic             count_inc;

  // NOTE: every signal gets a default before the case, so no path leaves
  // q_next/count_next unassigned and no latch is inferred.
  always_comb begin
    q_next     = q_r;
    count_next = count_r;
    count_inc  = 1'b0;
    case (mode_e'(bus.mode))
      MODE_SHL:  begin q_next = {q_r[WIDTH-2:0], bus.sin_r};    count_inc = 1'b1; end
      MODE_SHR:  begin q_next = {bus.sin_l, q_r[WIDTH-1:1]};    count_inc = 1'b1; end
      MODE_LOAD: begin q_next = bus.d;                          count_next = '0;  end
      MODE_ROL:  begin q_next = {q_r[WIDTH-2:0], q_r[WIDTH-1]}; count_inc = 1'b1; end
      MODE_ROR:  begin q_next = {q_r[0], q_r[WIDTH-1:1]};       count_inc = 1'b1; end
      MODE_SCLR: begin q_next = '0;                             count_next = '0;  end
      default:   ; // hold and reserved
    endcase
    // Shifting continues past saturation; only the count stops.
    if (count_inc && (count_r != FULL)) count_next = count_r + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; clear is synchronous and outranks enable.
  always_ff @(posedge clock) begin
    if (clear) begin
      q_r     <= RESET_VALUE;
      count_r <= '0;
    end else if (bus.enable) begin
      q_r     <= q_next;
      count_r <= count_next;
    end
  end

  // Outputs come straight from registers, so there is no sin_* to sout_* path.
  assign bus.q           = q_r;
  assign bus.sout_l      = q_r[WIDTH-1];
  assign bus.sout_r      = q_r[0];
  assign bus.shift_count = count_r;
  assign bus.drained     = (count_r == FULL);
endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg at WIDTH 8, 2 and 16. Stimulus
// pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_universal_shift_reg;
  typedef struct {
    logic [15:0] q;
    logic [4:0]  cnt;
    logic        drained;
    logic        sout_l;
    logic        sout_r;
    string       tag;
  } exp_t;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   checks_total  = 0;
  int   checks_passed = 0;

  exp_t exp8[$];
  exp_t exp2[$];
  exp_t exp16[$];

  universal_shift_reg_if #(.WIDTH(8))  bus8  ();
  universal_shift_reg_if #(.WIDTH(2))  bus2  ();
  universal_shift_reg_if #(.WIDTH(16)) bus16 ();

  universal_shift_reg #(.WIDTH(8),  .RESET_VALUE(8'hA5))    dut8  (.clock(clock), .clear(clear), .bus(bus8));
  universal_shift_reg #(.WIDTH(2),  .RESET_VALUE(2'b01))    dut2  (.clock(clock), .clear(clear), .bus(bus2));
  universal_shift_reg #(.WIDTH(16), .RESET_VALUE(16'hBEEF)) dut16 (.clock(clock), .clear(clear), .bus(bus16));

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(input int w, input logic [15:0] q, input int cnt, input string tag);
    exp_t e;
    e.q       = q;
    e.cnt     = 5'(cnt);
    e.drained = (cnt == w);
    e.sout_l  = q[w-1];
    e.sout_r  = q[0];
    e.tag     = tag;
    return e;
  endfunction

  task automatic compare(input exp_t e, input logic [15:0] q, input logic [4:0] cnt,
                         input logic dr, input logic sl, input logic sr);
    check({e.tag, ".q"},       32'(q),   32'(e.q));
    check({e.tag, ".count"},   32'(cnt), 32'(e.cnt));
    check({e.tag, ".drained"}, 32'(dr),  32'(e.drained));
    check({e.tag, ".sout_l"},  32'(sl),  32'(e.sout_l));
    check({e.tag, ".sout_r"},  32'(sr),  32'(e.sout_r));
  endtask

  // Monitor: outputs settle after posedge; compare on the following negedge.
  always @(negedge clock) begin
    exp_t e;
    if (exp8.size() > 0) begin
      e = exp8.pop_front();
      compare(e, 16'(bus8.q), 5'(bus8.shift_count), bus8.drained, bus8.sout_l, bus8.sout_r);
    end
    if (exp2.size() > 0) begin
      e = exp2.pop_front();
      compare(e, 16'(bus2.q), 5'(bus2.shift_count), bus2.drained, bus2.sout_l, bus2.sout_r);
    end
    if (exp16.size() > 0) begin
      e = exp16.pop_front();
      compare(e, bus16.q, 5'(bus16.shift_count), bus16.drained, bus16.sout_l, bus16.sout_r);
    end
  end

  task automatic op8(input logic clr, input logic en, input logic [2:0] m, input logic [7:0] dv,
                     input logic sl, input logic sr, input logic [7:0] eq, input int ec,
                     input string tag);
    @(negedge clock);
    clear         = clr;
    bus8.enable   = en;
    bus8.mode     = m;
    bus8.d        = dv;
    bus8.sin_l    = sl;
    bus8.sin_r    = sr;
    bus2.enable   = 1'b0;
    bus16.enable  = 1'b0;
    @(posedge clock);
    #1;
    exp8.push_back(mk(8, 16'(eq), ec, tag));
  endtask

  task automatic op_par(input logic [2:0] m, input logic [1:0] d2, input logic [15:0] d16,
                        input logic [1:0] e2q, input int e2c, input logic [15:0] e16q,
                        input int e16c, input string tag);
    @(negedge clock);
    clear        = 1'b0;
    bus8.enable  = 1'b0;
    bus2.enable  = 1'b1;
    bus2.mode    = m;
    bus2.d       = d2;
    bus2.sin_l   = 1'b0;
    bus2.sin_r   = 1'b0;
    bus16.enable = 1'b1;
    bus16.mode   = m;
    bus16.d      = d16;
    bus16.sin_l  = 1'b0;
    bus16.sin_r  = 1'b0;
    @(posedge clock);
    #1;
    exp2.push_back(mk(2, 16'(e2q), e2c, {tag, "_w2"}));
    exp16.push_back(mk(16, e16q, e16c, {tag, "_w16"}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] shr_q [8];
    logic [7:0] rol_q [10];
    int         rol_c [10];
    bus2.enable  = 1'b0;
    bus16.enable = 1'b0;
    bus8.enable  = 1'b0;

    // Clear with enable low and a load pending: clear wins everywhere.
    op8(1'b1, 1'b0, 3'b011, 8'hFF, 1'b0, 1'b0, 8'hA5, 0, "reset");
    exp2.push_back(mk(2, 16'h0001, 0, "reset_w2"));
    exp16.push_back(mk(16, 16'hBEEF, 0, "reset_w16"));

    // Load 1011_0010 and shift it out to the right with zeros behind it.
    shr_q = '{8'h59, 8'h2C, 8'h16, 8'h0B, 8'h05, 8'h02, 8'h01, 8'h00};
    op8(1'b0, 1'b1, 3'b011, 8'hB2, 1'b0, 1'b0, 8'hB2, 0, "load_b2");
    for (int i = 0; i < 8; i++)
      op8(1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b0, shr_q[i], i + 1, $sformatf("shr%0d", i + 1));

    // Rotate left past saturation: count sticks at 8, data keeps moving.
    rol_q = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81, 8'h03, 8'h06};
    rol_c = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8};
    op8(1'b0, 1'b1, 3'b011, 8'h81, 1'b0, 1'b0, 8'h81, 0, "load_81");
    for (int i = 0; i < 10; i++)
      op8(1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0, rol_q[i], rol_c[i], $sformatf("rol%0d", i + 1));

    // Load straight after saturation, then enable gating.
    op8(1'b0, 1'b1, 3'b011, 8'h3C, 1'b0, 1'b0, 8'h3C, 0, "load_3c");
    for (int i = 0; i < 5; i++)
      op8(1'b0, 1'b0, 3'b001, 8'h00, 1'b0, 1'b1, 8'h3C, 0, $sformatf("gated%0d", i + 1));
    op8(1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 1'b1, 8'h79, 1, "shl_sin1");

    // Priority: clear beats a simultaneous load; then soft clear and reserved.
    op8(1'b0, 1'b1, 3'b011, 8'hFF, 1'b0, 1'b0, 8'hFF, 0, "load_ff");
    op8(1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0, 8'hFE, 1, "shl1");
    op8(1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0, 8'hFC, 2, "shl2");
    op8(1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0, 8'hF8, 3, "shl3");
    op8(1'b1, 1'b1, 3'b011, 8'h12, 1'b0, 1'b0, 8'hA5, 0, "clr_over_load");
    op8(1'b0, 1'b1, 3'b110, 8'h12, 1'b0, 1'b0, 8'h00, 0, "soft_clear");
    op8(1'b0, 1'b1, 3'b111, 8'h12, 1'b0, 1'b0, 8'h00, 0, "rsvd1");
    op8(1'b0, 1'b1, 3'b111, 8'h12, 1'b0, 1'b0, 8'h00, 0, "rsvd2");

    // Rotate right, reserved/hold on nonzero data, shift right with a 1 in.
    op8(1'b0, 1'b1, 3'b011, 8'h5A, 1'b0, 1'b0, 8'h5A, 0, "load_5a");
    op8(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'h2D, 1, "ror1");
    op8(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'h96, 2, "ror2");
    op8(1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 8'h96, 2, "rsvd3");
    op8(1'b0, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 8'h96, 2, "hold");
    op8(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 8'hCB, 3, "shr_sin1");

    // Width 2 and width 16 load-and-drain side by side.
    op_par(3'b011, 2'b11, 16'hF00D, 2'b11, 0, 16'hF00D, 0, "pload");
    for (int k = 1; k <= 18; k++)
      op_par(3'b010, 2'b00, 16'h0000,
             2'(32'h3 >> k), (k < 2) ? k : 2,
             16'(32'hF00D >> k), (k < 16) ? k : 16,
             $sformatf("pshr%0d", k));

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && (exp8.size() + exp2.size() + exp16.size()) > 0; i++)
      @(negedge clock);
    #1;
    check("queues_drained", 32'(exp8.size() + exp2.size() + exp16.size()), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
